// File: rtl/operand_loader.sv
// Debounces the set/clear push-buttons and assembles two 32-bit operands
// byte by byte from the switch bank, flagging when all eight slots are loaded.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  inp,
  input  logic        set_btn,
  input  logic        clear_btn,
  output logic [31:0] num_a,
  output logic [31:0] num_b,
  output logic [2:0]  byte_idx,
  output logic        load_pulse,
  output logic        operands_valid,
  output logic        set_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned SET = 0;
  localparam int unsigned CLR = 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  state_t        state     [2];
  state_t        state_nxt [2];
  logic [CW-1:0] cnt       [2];
  logic [CW-1:0] cnt_nxt   [2];
  logic [1:0]    press;

  assign raw = {clear_btn, set_btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Both buttons share the same debounce FSM; the press strobe is asserted
  // combinationally in the cycle whose edge moves PRESS_WAIT into HELD.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      press[i]     = 1'b0;
      case (state[i])
        IDLE: begin
          if (sync2[i]) begin
            state_nxt[i] = PRESS_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[i]) begin
            state_nxt[i] = IDLE;
          end else if (cnt[i] == CNT_MAX) begin
            state_nxt[i] = HELD;
            press[i]     = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        HELD: begin
          if (!sync2[i]) begin
            state_nxt[i] = RELEASE_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2[i]) begin
            state_nxt[i] = HELD;
          end else if (cnt[i] == CNT_MAX) begin
            state_nxt[i] = IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  assign set_db = (state[SET] == HELD) || (state[SET] == RELEASE_WAIT);

  // Clear outranks a coincident set press: nothing is written that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_a          <= '0;
      num_b          <= '0;
      byte_idx       <= '0;
      load_pulse     <= 1'b0;
      operands_valid <= 1'b0;
    end else if (press[CLR]) begin
      num_a          <= '0;
      num_b          <= '0;
      byte_idx       <= '0;
      load_pulse     <= 1'b0;
      operands_valid <= 1'b0;
    end else if (press[SET]) begin
      case (byte_idx)
        3'd0: num_a[7:0]   <= inp;
        3'd1: num_a[15:8]  <= inp;
        3'd2: num_a[23:16] <= inp;
        3'd3: num_a[31:24] <= inp;
        3'd4: num_b[7:0]   <= inp;
        3'd5: num_b[15:8]  <= inp;
        3'd6: num_b[23:16] <= inp;
        3'd7: num_b[31:24] <= inp;
        default: ;
      endcase
      byte_idx   <= byte_idx + 3'd1;
      load_pulse <= 1'b1;
      if (byte_idx == 3'd7) begin
        operands_valid <= 1'b1;
      end else if (byte_idx == 3'd0) begin
        operands_valid <= 1'b0;
      end
    end else begin
      load_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES=4: reset, timing,
// bounce rejection, table-driven fill/wrap, clear priority and reset mid-press.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  inp = '0;
  logic        set_btn = 1'b0;
  logic        clear_btn = 1'b0;
  logic [31:0] num_a;
  logic [31:0] num_b;
  logic [2:0]  byte_idx;
  logic        load_pulse;
  logic        operands_valid;
  logic        set_db;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inp            (inp),
    .set_btn        (set_btn),
    .clear_btn      (clear_btn),
    .num_a          (num_a),
    .num_b          (num_b),
    .byte_idx       (byte_idx),
    .load_pulse     (load_pulse),
    .operands_valid (operands_valid),
    .set_db         (set_db)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_pulse === 1'b1) pulse_cnt++;

  typedef struct {
    logic [7:0]  inp;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [2:0]  exp_idx;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_btn = 1'b0;
    clear_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] b);
    @(negedge clk);
    inp = b;
    set_btn = 1'b1;
    repeat (10) @(negedge clk);
    set_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int p0;
    vecs[0] = '{8'h01, 32'h00000001, 32'h00000000, 3'd1, 1'b0};
    vecs[1] = '{8'h02, 32'h00000201, 32'h00000000, 3'd2, 1'b0};
    vecs[2] = '{8'h03, 32'h00030201, 32'h00000000, 3'd3, 1'b0};
    vecs[3] = '{8'h04, 32'h04030201, 32'h00000000, 3'd4, 1'b0};
    vecs[4] = '{8'h05, 32'h04030201, 32'h00000005, 3'd5, 1'b0};
    vecs[5] = '{8'h06, 32'h04030201, 32'h00000605, 3'd6, 1'b0};
    vecs[6] = '{8'h07, 32'h04030201, 32'h00070605, 3'd7, 1'b0};
    vecs[7] = '{8'h08, 32'h04030201, 32'h08070605, 3'd0, 1'b1};
    vecs[8] = '{8'hAA, 32'h040302AA, 32'h08070605, 3'd1, 1'b0};

    // 1. reset, then idle for 20 cycles
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ab", {num_a, num_b}, 64'd0);
      chk("idle_misc", {60'd0, byte_idx, load_pulse, operands_valid, set_db}, 64'd0);
    end

    // 2. clean press, exact latency
    @(negedge clk);
    inp = 8'h11;
    set_btn = 1'b1;
    repeat (6) @(negedge clk);
    chk("early_idx", 64'(byte_idx), 64'd0);
    chk("early_pulse", 64'(load_pulse), 64'd0);
    chk("early_db", 64'(set_db), 64'd0);
    @(negedge clk);
    chk("clean_a", 64'(num_a), 64'h11);
    chk("clean_idx", 64'(byte_idx), 64'd1);
    chk("clean_db", 64'(set_db), 64'd1);
    chk("clean_pulse", 64'(load_pulse), 64'd1);
    @(negedge clk);
    chk("clean_pulse_fall", 64'(load_pulse), 64'd0);
    repeat (2) @(negedge clk);
    set_btn = 1'b0;
    repeat (6) @(negedge clk);
    chk("release_db_hold", 64'(set_db), 64'd1);
    @(negedge clk);
    chk("release_db_fall", 64'(set_db), 64'd0);
    chk("clean_count", 64'(pulse_cnt), 64'd1);

    // 3. bounce rejection, then a held press with a short low glitch
    apply_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < 30; i++) begin
      set_btn = (i % 3 != 2);
      @(negedge clk);
    end
    set_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_pulses", 64'(pulse_cnt - p0), 64'd0);
    chk("bounce_idx", 64'(byte_idx), 64'd0);
    chk("bounce_a", 64'(num_a), 64'd0);
    inp = 8'h5A;
    set_btn = 1'b1;
    repeat (10) @(negedge clk);
    set_btn = 1'b0;
    repeat (2) @(negedge clk);
    set_btn = 1'b1;
    repeat (10) @(negedge clk);
    set_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("glitch_a", 64'(num_a), 64'h5A);
    chk("glitch_idx", 64'(byte_idx), 64'd1);

    // 4. table-driven fill and wrap
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      p0 = pulse_cnt;
      press(vecs[i].inp);
      chk($sformatf("fill%0d_a", i), 64'(num_a), 64'(vecs[i].exp_a));
      chk($sformatf("fill%0d_b", i), 64'(num_b), 64'(vecs[i].exp_b));
      chk($sformatf("fill%0d_idx", i), 64'(byte_idx), 64'(vecs[i].exp_idx));
      chk($sformatf("fill%0d_valid", i), 64'(operands_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("fill%0d_pulses", i), 64'(pulse_cnt - p0), 64'd1);
    end

    // 5. clear wins over a coincident set
    apply_reset();
    press(8'h01);
    press(8'h02);
    press(8'h03);
    chk("pre_clear_idx", 64'(byte_idx), 64'd3);
    p0 = pulse_cnt;
    @(negedge clk);
    inp = 8'hEE;
    set_btn = 1'b1;
    clear_btn = 1'b1;
    repeat (10) @(negedge clk);
    set_btn = 1'b0;
    clear_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("clr_ab", {num_a, num_b}, 64'd0);
    chk("clr_idx", 64'(byte_idx), 64'd0);
    chk("clr_pulses", 64'(pulse_cnt - p0), 64'd0);
    press(8'h77);
    chk("after_clr_a", 64'(num_a), 64'h77);
    chk("after_clr_idx", 64'(byte_idx), 64'd1);

    // 6. reset asserted while set is mid-debounce, released with set held
    apply_reset();
    p0 = pulse_cnt;
    @(negedge clk);
    inp = 8'h33;
    set_btn = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstpw_early_idx", 64'(byte_idx), 64'd0);
    chk("rstpw_early_pulses", 64'(pulse_cnt - p0), 64'd0);
    @(negedge clk);
    chk("rstpw_idx", 64'(byte_idx), 64'd1);
    chk("rstpw_pulse", 64'(load_pulse), 64'd1);
    chk("rstpw_a", 64'(num_a), 64'h33);
    repeat (4) @(negedge clk);
    set_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstpw_pulses", 64'(pulse_cnt - p0), 64'd1);

    // 1b. asynchronous reset mid-run clears outputs without a clock edge
    press(8'h44);
    chk("pre_async_a", 64'(num_a), 64'h4433);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ab", {num_a, num_b}, 64'd0);
    chk("async_misc", {60'd0, byte_idx, load_pulse, operands_valid, set_db}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
